data_mem_loader: RTL

Host-side loader that fills the pipeline's data memory before execution, the write-direction counterpart to the end-of-run data-memory dump. It accepts a byte stream over a valid/ready handshake, packs little-endian bytes into DATA_WIDTH-bit words, and writes them to consecutive data-memory addresses starting at 0. While a load is in progress it holds the pipelined core in reset through `core_hold`, and it signals completion with a one-cycle `done` pulse.

---
 rtl/data_mem_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_loader.sv
// -----------------------------------------------------------------------------
// data_mem_loader
//
// Host-side loader that fills the pipeline's data memory before execution.
// A byte stream arriving over a valid/ready handshake is packed little-endian
// into DATA_WIDTH-bit words, and the words are written to consecutive
// data-memory addresses starting at 0. While a load is running the core is
// held in reset through core_hold. Completion is flagged by a one-cycle done.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   load request, only honoured while idle
//   length        in   words to load (ADDRESS_WIDTH+1 bits), sampled with start
//   in_valid      in   byte-stream valid
//   in_byte       in   byte-stream data
//   in_ready      out  loader can accept a byte this cycle
//   mem_we        out  data-memory write strobe (one cycle per word)
//   mem_addr      out  data-memory write address
//   mem_wdata     out  data-memory write data
//   core_hold     out  holds the pipeline in reset while loading
//   busy          out  load in progress
//   done          out  one-cycle completion pulse
//   words_loaded  out  words written in the current or most recent load
//
// All outputs are decoded from registered state or taken directly from
// registers, so there is no combinational path from any input to an output.
// -----------------------------------------------------------------------------
module data_mem_loader #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MEM_SIZE      = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH:0]   length,
  input  logic                     in_valid,
  input  logic [7:0]               in_byte,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     core_hold,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH:0]   words_loaded
);

  // Bytes per word, rounded up; the top byte may be only partly used.
  localparam int BPW   = (DATA_WIDTH + 7) / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int LEN_W = ADDRESS_WIDTH + 1;

  localparam logic [LEN_W-1:0] MEM_WORDS = LEN_W'(MEM_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BPW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]    asm_q, asm_d;
  logic [ADDRESS_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [LEN_W-1:0]         eff_len_q, eff_len_d;
  logic [LEN_W-1:0]         words_q, words_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

  // Assembly register with the incoming byte merged into its lane.
  logic [DATA_WIDTH-1:0]    asm_merged;
  logic [LEN_W-1:0]         len_clamped;

  // One lane per byte of the word. The top lane is narrowed to the bits that
  // fit inside DATA_WIDTH, so the excess high bits of the last byte simply
  // never reach the register.
  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : g_lane
      localparam int LO = gi * 8;
      localparam int HI = ((LO + 8) < DATA_WIDTH) ? (LO + 7) : (DATA_WIDTH - 1);
      assign asm_merged[HI:LO] = (byte_idx_q == IDX_W'(gi)) ? in_byte[HI-LO:0]
                                                             : asm_q[HI:LO];
    end
  endgenerate

  // Oversized requests are clamped to the memory depth, never wrapped.
  assign len_clamped = (length > MEM_WORDS) ? MEM_WORDS : length;

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    asm_d       = asm_q;
    word_addr_d = word_addr_q;
    eff_len_d   = eff_len_q;
    words_d     = words_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          words_d = '0;
          if (length == '0) begin
            state_d = FINISH;
          end else begin
            eff_len_d   = len_clamped;
            byte_idx_d  = '0;
            word_addr_d = '0;
            asm_d       = '0;
            state_d     = RECV;
          end
        end
      end

      RECV: begin
        if (in_valid) begin
          if (byte_idx_q == LAST_IDX) begin
            // Capture address and data into the output registers so they
            // stay stable through WRITE and keep showing the last write after.
            mem_addr_d  = word_addr_q;
            mem_wdata_d = asm_merged;
            state_d     = WRITE;
          end else begin
            asm_d      = asm_merged;
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end

      WRITE: begin
        words_d    = words_q + 1'b1;
        byte_idx_d = '0;
        asm_d      = '0;
        if (words_d == eff_len_q) begin
          state_d = FINISH;
        end else begin
          // Only advance when another word follows, so the address never
          // rolls past MEM_SIZE-1 even on a full-memory load.
          word_addr_d = word_addr_q + 1'b1;
          state_d     = RECV;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      word_addr_q <= '0;
      eff_len_q   <= '0;
      words_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      word_addr_q <= word_addr_d;
      eff_len_q   <= eff_len_d;
      words_q     <= words_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready     = (state_q == RECV);
  assign mem_we       = (state_q == WRITE);
  assign busy         = (state_q == RECV) || (state_q == WRITE);
  assign core_hold    = busy;
  assign done         = (state_q == FINISH);
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_q;

endmodule
